// File: rtl/add32_reg.sv
// add32_reg: N-bit ripple-carry adder with carry-in/carry-out and registered outputs.
// Latency: 1 clock from operand sample to s/c_out/out_valid.
// Backpressure: none; accepts one operation per cycle, out_valid is a single-cycle qualifier.
module add32_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         out_valid
);

  // Carry chain: carry[i] enters bit i, carry[N] is the carry out of the MSB.
  logic [N:0]   carry;
  logic [N-1:0] sum;

  assign carry[0] = c_in;

  // One full adder per bit, rippling the carry from LSB to MSB.
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

  logic [N-1:0] s_q, s_d;
  logic         c_q, c_d;
  logic         v_q, v_d;

  // Next state: capture on valid input, otherwise hold the result and drop out_valid.
  always_comb begin
    s_d = s_q;
    c_d = c_q;
    v_d = 1'b0;
    if (in_valid) begin
      s_d = sum;
      c_d = carry[N];
      v_d = 1'b1;
    end
  end

  // Output register; synchronous active-low reset overrides any capture at that edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q <= '0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign s         = s_q;
  assign c_out     = c_q;
  assign out_valid = v_q;

endmodule

// File: tb/tb_add32_reg.sv
// tb_add32_reg: directed and random checks of add32_reg against hand values and a 33-bit sum model.
// Latency: results checked 1 ns after the edge that captures them.
// Backpressure: not applicable; inputs are driven every cycle.
module tb_add32_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        c_in = 1'b0;
  logic [31:0] s;
  logic        c_out;
  logic        out_valid;

  int n_pass  = 0;
  int n_total = 0;

  add32_reg #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .s         (s),
    .c_out     (c_out),
    .out_valid (out_valid)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Compare {out_valid, c_out, s} against an expected triple.
  task automatic chk(input string tag, input logic exp_v, input logic exp_c, input logic [31:0] exp_s);
    n_total++;
    assert ({out_valid, c_out, s} === {exp_v, exp_c, exp_s})
      n_pass++;
    else
      $error("FAIL %s observed v=%b c=%b s=%h expected v=%b c=%b s=%h",
             tag, out_valid, c_out, s, exp_v, exp_c, exp_s);
  endtask

  // Apply one set of inputs across one rising edge, then settle past the edge.
  task automatic step(input logic r, input logic v, input logic [31:0] ai,
                      input logic [31:0] bi, input logic ci);
    rst      = r;
    in_valid = v;
    a        = ai;
    b        = bi;
    c_in     = ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc, rv, rr;
    logic [32:0] m;
    logic [31:0] exp_s;
    logic        exp_c, exp_v;

    // Reset held for two edges with valid random operands: outputs stay cleared.
    step(1'b0, 1'b1, $urandom, $urandom, 1'b1);
    chk("reset_1", 1'b0, 1'b0, 32'h0000_0000);
    step(1'b0, 1'b1, $urandom, $urandom, 1'b0);
    chk("reset_2", 1'b0, 1'b0, 32'h0000_0000);

    // Idle after reset: nothing valid, nothing held except zeros.
    step(1'b1, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1);
    chk("idle_after_reset", 1'b0, 1'b0, 32'h0000_0000);

    // Wrap-around.
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk("wrap", 1'b1, 1'b1, 32'h0000_0000);

    // Carry-in ripples the full width.
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    chk("cin_full_ripple", 1'b1, 1'b1, 32'h0000_0000);

    // Carry-in ripples into the MSB only.
    step(1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    chk("cin_to_msb", 1'b1, 1'b0, 32'h8000_0000);

    // Maximum operands.
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("max", 1'b1, 1'b1, 32'hFFFF_FFFF);

    // All zero.
    step(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
    chk("zero", 1'b1, 1'b0, 32'h0000_0000);

    // Mixed pattern: 0x12345678 + 0x9ABCDEF0 + 1 = 0xACF13569, no carry.
    step(1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    chk("mixed", 1'b1, 1'b0, 32'hACF1_3569);

    // Alternating bits: 0xAAAAAAAA + 0x55555555 + 1 = 0x1_00000000.
    step(1'b1, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    chk("alt_bits", 1'b1, 1'b1, 32'h0000_0000);

    // Valid dropped: previous result held, out_valid low.
    step(1'b1, 1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0);
    chk("hold_on_invalid", 1'b0, 1'b1, 32'h0000_0000);

    // 0x80000000 + 0x80000000 + 0 = 0x1_00000000.
    step(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("msb_carry", 1'b1, 1'b1, 32'h0000_0000);

    // Back-to-back random stream with a dropped-valid gap and a one-edge reset.
    exp_s = 32'h0000_0000;
    exp_c = 1'b1;
    exp_v = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rv = (i != 400);
      rr = (i != 800);
      step(rr, rv, ra, rb, rc);
      m = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      if (!rr) begin
        exp_s = 32'h0;
        exp_c = 1'b0;
        exp_v = 1'b0;
      end else if (rv) begin
        exp_s = m[31:0];
        exp_c = m[32];
        exp_v = 1'b1;
      end else begin
        exp_v = 1'b0;
      end
      if (i == 400)
        chk("stream_gap", exp_v, exp_c, exp_s);
      else if (i == 800)
        chk("stream_reset", exp_v, exp_c, exp_s);
      else if (i == 801)
        chk("stream_after_reset", exp_v, exp_c, exp_s);
      else
        chk("stream", exp_v, exp_c, exp_s);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
